// File: rtl/mips_prog_loader_pkg.sv
// Shared MIPS definitions: loader FSM encoding, frame sync byte and imem geometry.
package mips_prog_loader_pkg;

  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam logic [7:0]  SYNC_DEF   = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } ld_state_e;

  // Big-endian word assembly: the three earlier bytes occupy the upper bits.
  function automatic logic [WORD_W-1:0] pack_word(input logic [23:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/mips_prog_loader.sv
// Serial program loader: receives a SYNC/length/data/checksum byte frame, writes the
// words into instruction memory and releases the CPU only after a good checksum.
module mips_prog_loader
  import mips_prog_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter logic [7:0]  SYNC   = SYNC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  ld_state_e         state, state_d;
  logic [ADDR_W-1:0] len_m1, len_m1_d;
  logic [ADDR_W-1:0] word_cnt, word_cnt_d;
  logic [1:0]        byte_cnt, byte_cnt_d;
  logic [23:0]       shift, shift_d;
  logic [7:0]        csum, csum_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic              accept;

  assign accept = in_valid && in_ready;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state;
    len_m1_d   = len_m1;
    word_cnt_d = word_cnt;
    byte_cnt_d = byte_cnt;
    shift_d    = shift;
    csum_d     = csum;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;

    unique case (state)
      S_IDLE, S_ERR: begin
        if (accept && in_data == SYNC) state_d = S_LEN;
      end
      S_LEN: begin
        if (accept) begin
          if (in_data == 8'd0 || 32'(in_data) > DEPTH) begin
            state_d = S_ERR;
          end else begin
            len_m1_d   = ADDR_W'(in_data - 8'd1);
            word_cnt_d = '0;
            byte_cnt_d = '0;
            csum_d     = '0;
            shift_d    = '0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum ^ in_data;
          shift_d    = {shift[15:0], in_data};
          byte_cnt_d = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = word_cnt;
            wdata_d = pack_word(shift, in_data);
            // Last word: stop counting so the address never passes N-1
            if (word_cnt == len_m1) state_d = S_CHECK;
            else word_cnt_d = ADDR_W'(word_cnt + 1'b1);
          end
        end
      end
      S_CHECK: begin
        if (accept) state_d = (in_data == csum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        if (reload) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and output registers; outputs follow the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      len_m1     <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      csum       <= '0;
      in_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_d;
      len_m1     <= len_m1_d;
      word_cnt   <= word_cnt_d;
      byte_cnt   <= byte_cnt_d;
      shift      <= shift_d;
      csum       <= csum_d;
      in_ready   <= (state_d != S_DONE);
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      cpu_reset  <= (state_d != S_DONE);
      done       <= (state_d == S_DONE);
      error      <= (state_d == S_ERR);
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: expected imem writes are queued by the
// stimulus and matched by a negedge monitor; status outputs are checked inline.
module tb_mips_prog_loader;

  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  mips_prog_loader #(.DEPTH(16), .ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [35:0] exp_q[$];
  logic [7:0]  demo [20];
  logic [31:0] demo_w [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (imem_we) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          fails++;
          $display("FAIL imem_write: got addr %h data %h expected addr %h data %h",
                   imem_addr, imem_wdata, e[35:32], e[31:0]);
        end
      end
    end
    if (done && error) begin
      tests++;
      fails++;
      $display("FAIL done_error_exclusive: got done=1 error=1 expected not both");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte until accepted, then idle for 'gap' cycles
  task automatic send_byte(input logic [7:0] b, input int gap);
    int  n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    while (!acc && n < 50) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no accept for byte %h expected accept within 50 cycles", b);
    end
    repeat (gap) tick();
  endtask

  task automatic send_demo(input logic [7:0] cks, input int gap);
    send_byte(8'hA5, gap);
    send_byte(8'h05, gap);
    for (int i = 0; i < 5; i++) exp_q.push_back({4'(i), demo_w[i]});
    for (int i = 0; i < 20; i++) send_byte(demo[i], gap);
    send_byte(cks, gap);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  initial begin
    demo = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h0A, 8'h00, 8'h22,
             8'h18, 8'h20, 8'h00, 8'h60, 8'h20, 8'h20, 8'hAC, 8'h04, 8'h00, 8'h00};
    demo_w = '{32'h20010005, 32'h2002000A, 32'h00221820, 32'h00602020, 32'hAC040000};

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    // Garbage before SYNC, then the good demo frame
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
    chk("garbage_error", 32'(error), 32'd0);
    send_demo(8'hDE, 0);
    chk("good_done", 32'(done), 32'd1);
    chk("good_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("good_error", 32'(error), 32'd0);
    chk("good_in_ready", 32'(in_ready), 32'd0);

    // Bytes offered while DONE are not taken
    in_valid = 1'b1; in_data = 8'hA5;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("done_hold", 32'(done), 32'd1);
    chk("done_hold_ready", 32'(in_ready), 32'd0);

    pulse_reload();
    chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_in_ready", 32'(in_ready), 32'd1);

    // Bad checksum with gaps: writes still happen, then ERR
    send_demo(8'hDF, 1);
    chk("badck_error", 32'(error), 32'd1);
    chk("badck_done", 32'(done), 32'd0);
    chk("badck_cpu_reset", 32'(cpu_reset), 32'd1);
    send_byte(8'hA5, 0);
    chk("sync_clears_error", 32'(error), 32'd0);

    // Length boundaries: 0 and 17 are rejected
    send_byte(8'h00, 0);
    chk("len0_error", 32'(error), 32'd1);
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    chk("len17_error", 32'(error), 32'd1);
    pulse_reload();
    chk("reload_ignored_err", 32'(error), 32'd1);

    // Recover from ERR with a good frame, wide gaps
    send_demo(8'hDE, 2);
    chk("recover_done", 32'(done), 32'd1);
    chk("recover_cpu_reset", 32'(cpu_reset), 32'd0);
    pulse_reload();

    // Reset after six data bytes: only word 0 written
    send_byte(8'hA5, 0);
    send_byte(8'h05, 0);
    exp_q.push_back({4'd0, demo_w[0]});
    for (int i = 0; i < 6; i++) send_byte(demo[i], 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_imem_addr", 32'(imem_addr), 32'd0);
    chk("midrst_imem_wdata", imem_wdata, 32'd0);
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midrst_error", 32'(error), 32'd0);
    repeat (10) tick();
    send_demo(8'hDE, 0);
    chk("post_rst_done", 32'(done), 32'd1);

    repeat (5) tick();
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
